rr_arbiter_8: RTL
=================

Name: rr_arbiter_8

Overview:
- Round-robin arbiter sharing one resource among 8 requesters.
- Grant is one-hot (8'b00000001 << gnt_idx) and reuses the team's 3-to-8 one-hot decode convention.
- Sits in front of shared datapath resources (bus port, memory bank) and sequences ownership with a req/release handshake.
- Registered outputs; 1-cycle arbitration latency.

Parameters:
- MAX_HOLD, 16, max consecutive grant cycles before forced rotation (used only with RR_TIMEOUT_EN); legal range 2..255.
- CNT_W, 8, width of hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  arbitration enable; 0 blocks new grants only.
- req  input  8  request per requester; held high for the whole ownership.
- gnt  output  8  one-hot grant; 8'b0 when no owner.
- gnt_idx  output  3  index of current owner; valid only when gnt_valid=1.
- gnt_valid  output  1  1 when any grant is active.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset (rst=1 at an edge): gnt=8'b0, gnt_idx=3'd0, gnt_valid=0, state=IDLE, ptr=3'd0, hold_cnt=0. Reset mid-grant drops the grant on the next edge, no handshake.
- ptr is the search start. Selection = first req[i] set, scanning i=ptr, ptr+1 … wrapping mod 8.
- State IDLE:
  - If en=1 and req!=0 at an edge, grant the selected i. Next cycle: gnt=1<<i, gnt_idx=i, gnt_valid=1, ptr=i+1 mod 8 (7 wraps to 0), hold_cnt=0. Go to GRANT.
  - Otherwise remain IDLE.
- State GRANT:
  - Release: req[gnt_idx]=0 sampled at an edge.
    - If en=1 and other requests are pending, switch directly to the selected next owner on the following cycle, with no idle bubble.
    - Otherwise, next cycle gnt=0, gnt_valid=0, gnt_idx holds its last value, go to IDLE.
  - Hold: req[gnt_idx]=1 keeps the grant; hold_cnt increments and saturates at MAX_HOLD-1.
  - en=0 during GRANT does not revoke the owner. It only prevents a successor at release, so the block goes to IDLE.
  - The releasing requester is excluded from selection in the same cycle. It may win again after a full rotation.
- Simultaneous release by the owner and a new request from another requester at the same edge: the new request is eligible, and the handoff occurs.
- req bits of non-owners may toggle freely. Requests are not latched, so a request dropped before being granted is lost.
- Invariants: gnt is always zero or one-hot. gnt == (gnt_valid ? 1<<gnt_idx : 0).

Optional Feature:
- Macro: RR_TIMEOUT_EN.
- Defined:
  - When hold_cnt == MAX_HOLD-1, en=1, and any other req bit is set at an edge, the owner is pre-empted. The grant moves to the selected next requester on the next cycle, ptr advances, and hold_cnt resets.
  - If no other requester is pending, the owner keeps the grant and hold_cnt stays saturated.
- Undefined:
  - No pre-emption; the owner holds until release.
  - MAX_HOLD is ignored.
  - hold_cnt logic is removed.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req=8'hFF -> gnt=0, gnt_valid=0 during reset. First edge after rst=0 samples req; next cycle gnt=8'h01, gnt_idx=0.
- Rotation: req=8'hFF held; each owner drops its req for one cycle then re-raises -> gnt sequence 01,02,04,08,10,20,40,80,01 with no bubbles.
- Wrap and skip: ptr=6 after granting 5, req=8'b00001001 -> next gnt=8'h01 (idx 0), then 8'h08 (idx 3).
- Enable gating: owner idx 2, en=0, req=8'h84; drop req[2] -> gnt=0, IDLE. Set en=1 -> gnt=8'h80 one cycle later.
- Timeout (RR_TIMEOUT_EN, MAX_HOLD=4): req=8'h03 held constant -> gnt=01 for 4 cycles, then 02 for 4 cycles, alternating. With req=8'h01 only, gnt=01 stays indefinitely.
- Reset mid-grant: owner idx 5, rst=1 for 1 cycle -> next cycle gnt=0, gnt_idx=0. With req=8'h20 still high, gnt=8'h20 returns 1 cycle after rst falls.

Source files
------------

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8 - round-robin arbiter for 8 requesters with a req/release handshake.
// The grant, index and valid outputs are registered, so arbitration takes one cycle.
// The search pointer starts just past the most recent winner.
// Optional build macro RR_TIMEOUT_EN: an owner that has held the grant for
// MAX_HOLD cycles is pre-empted if another requester is waiting.
// Without the macro the hold counter does not exist and MAX_HOLD only goes
// through the parameter sanity check.
module rr_arbiter_8 #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_valid
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t     state_reg;
   logic [2:0] ptr_reg;
   logic [7:0] gnt_reg;
   logic [2:0] gnt_idx_reg;
   logic       gnt_valid_reg;

   // Candidates are every requester except the current owner.
   // When idle gnt_reg is zero, so every request is a candidate.
   logic [7:0] cand;
   logic [7:0] rot;
   logic [2:0] off;
   logic [2:0] sel_idx;
   logic [7:0] sel_onehot;
   logic       any_cand;
   logic       owner_req;
   logic       release_now;
   logic       timeout_hit;
   logic       take;

   // Reject parameter combinations the hold counter cannot represent.
   generate
      if (MAX_HOLD < 2 || MAX_HOLD > 255 || (64'd1 << CNT_W) <= 64'(MAX_HOLD)) begin : g_param_err
         $error("rr_arbiter_8: MAX_HOLD must be 2..255 and below 2**CNT_W");
      end
   endgenerate

   assign cand      = req & ~gnt_reg;
   assign any_cand  = |cand;
   // The owner is the single set bit of gnt_reg, so this is req[gnt_idx] without indexing.
   assign owner_req = |(req & gnt_reg);

   // Rotate the candidates so that bit 0 is the requester at ptr.
   // A fixed low-to-high priority search then implements the circular scan.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_rot
         logic [2:0] src;
         assign src     = ptr_reg + 3'(gi);
         assign rot[gi] = cand[src];
      end
   endgenerate

   // Find the lowest set bit of the rotated vector; its offset is counted from ptr.
   always_comb begin
      off = 3'd0;
      for (int k = 7; k >= 0; k--) begin
         if (rot[k]) begin
            off = 3'(k);
         end
      end
   end

   assign sel_idx = ptr_reg + off;

   // Decode the 3-bit index into the one-hot grant vector.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_dec
         assign sel_onehot[gi] = (sel_idx == 3'(gi));
      end
   endgenerate

`ifdef RR_TIMEOUT_EN
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   logic [CNT_W-1:0] hold_cnt_reg;

   // The owner is still requesting and has used up its hold budget.
   always_comb begin
      timeout_hit = (state_reg == GRANT) && owner_req && (hold_cnt_reg == HOLD_LAST);
   end
`else
   // No pre-emption: only a release can end an ownership.
   always_comb begin
      timeout_hit = 1'b0;
   end
`endif

   // Decide whether this edge hands the resource to a new owner.
   // A handoff happens when idle, when the owner releases, or when the owner times out,
   // and it needs en=1 and a waiting candidate.
   always_comb begin
      release_now = (state_reg == GRANT) && !owner_req;
      take        = en && any_cand && ((state_reg == IDLE) || release_now || timeout_hit);
   end

   // Ownership FSM with registered grant outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         ptr_reg       <= 3'd0;
         gnt_reg       <= 8'd0;
         gnt_idx_reg   <= 3'd0;
         gnt_valid_reg <= 1'b0;
`ifdef RR_TIMEOUT_EN
         hold_cnt_reg  <= '0;
`endif
      end else if (take) begin
         state_reg     <= GRANT;
         ptr_reg       <= sel_idx + 3'd1;
         gnt_reg       <= sel_onehot;
         gnt_idx_reg   <= sel_idx;
         gnt_valid_reg <= 1'b1;
`ifdef RR_TIMEOUT_EN
         hold_cnt_reg  <= '0;
`endif
      end else if (release_now) begin
         // The owner released and there is no successor. gnt_idx keeps the last owner.
         state_reg     <= IDLE;
         gnt_reg       <= 8'd0;
         gnt_valid_reg <= 1'b0;
      end else if (state_reg == GRANT) begin
`ifdef RR_TIMEOUT_EN
         if (hold_cnt_reg != HOLD_LAST) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
         end
`endif
      end
   end

   assign gnt       = gnt_reg;
   assign gnt_idx   = gnt_idx_reg;
   assign gnt_valid = gnt_valid_reg;

endmodule
